// File: rtl/pc_ctrl.sv
// Next-PC sequencer for the fetch-stage PC register: picks trap / branch / pending / jump / pc+4,
// gates PCWrite on fetch readiness, stalls and halt, and emits the matching pipeline flush strobes.
module pc_ctrl #(
    parameter int           W            = 32,
    parameter logic [W-1:0] RESET_VECTOR = '0,
    parameter logic [W-1:0] TRAP_VECTOR  = W'(32'h0000_0100)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    input  logic         imem_ready,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic         jmp_valid,
    input  logic [W-1:0] jmp_target,
    input  logic         trap,
    input  logic         halt_req,
    input  logic         resume,
    output logic         PCWrite,
    output logic [W-1:0] n_pc,
    output logic         flush_if_id,
    output logic         flush_id_ex,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_JUMP   = 2'd1,
        RD_BRANCH = 2'd2,
        RD_TRAP   = 2'd3
    } redir_t;

    state_t       r_state;
    redir_t       r_pend_kind;
    logic [W-1:0] r_pend_target;

    redir_t       w_kind;
    logic [W-1:0] w_target;
    logic [W-1:0] w_seq;
    logic         w_redirect;
    logic         w_apply;
    logic         w_hold_trap;

    assign w_seq = pc + W'(4);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_kind   = RD_NONE;
        w_target = w_seq;
        case (r_state)
            ST_RUN: begin
                if (trap) begin
                    w_kind   = RD_TRAP;
                    w_target = TRAP_VECTOR;
                end else if (br_taken) begin
                    w_kind   = RD_BRANCH;
                    w_target = br_target;
                end else if (r_pend_kind != RD_NONE) begin
                    w_kind   = r_pend_kind;
                    w_target = r_pend_target;
                end else if (jmp_valid && !stall) begin
                    w_kind   = RD_JUMP;
                    w_target = jmp_target;
                end
            end
            ST_HALT: begin
                if (trap) begin
                    w_kind   = RD_TRAP;
                    w_target = TRAP_VECTOR;
                end
            end
            default: ;
        endcase
    end

    assign w_redirect  = (w_kind != RD_NONE);
    assign w_apply     = w_redirect && imem_ready;
    // A branch arriving behind a buffered trap must not displace it.
    assign w_hold_trap = (w_kind == RD_BRANCH) && (r_pend_kind == RD_TRAP);

    always_comb begin
        PCWrite     = 1'b0;
        n_pc        = w_seq;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst) begin
            n_pc = RESET_VECTOR;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    PCWrite = 1'b1;
                    n_pc    = RESET_VECTOR;
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        PCWrite = imem_ready;
                        n_pc    = w_target;
                    end else begin
                        PCWrite = imem_ready && !stall && !halt_req;
                    end
                end
                ST_HALT: begin
                    PCWrite = w_apply;
                    n_pc    = w_target;
                end
                default: ;
            endcase
            flush_if_id = w_apply;
            flush_id_ex = w_apply && (w_kind == RD_TRAP || w_kind == RD_BRANCH);
        end
    end

    assign state = r_state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_pend_kind   <= RD_NONE;
            r_pend_target <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  if (!w_redirect && halt_req) r_state <= ST_HALT;
                ST_HALT: if (trap || resume) r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase

            if (w_apply) begin
                r_pend_kind <= RD_NONE;
            end else if (w_redirect && !w_hold_trap) begin
                r_pend_kind   <= w_kind;
                r_pend_target <= w_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a queue-based next-PC model is checked against the DUT every cycle,
// with literal per-cycle expectations from the test plan pinning the model.
module tb_pc_ctrl;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    localparam int JUMP   = 1;
    localparam int BRANCH = 2;
    localparam int TRAP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_ready, stall, br_taken, jmp_valid, trap, halt_req, resume;
    logic [31:0] br_target, jmp_target;
    logic        PCWrite, flush_if_id, flush_id_ex;
    logic [31:0] n_pc;
    logic [1:0]  state;

    pc_ctrl #(.W(W), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_ready(imem_ready), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
        .jmp_target(jmp_target), .trap(trap), .halt_req(halt_req), .resume(resume),
        .PCWrite(PCWrite), .n_pc(n_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] target;
    } redir_t;

    function automatic redir_t mk(input int kind, input logic [31:0] target);
        redir_t r;
        r.kind   = kind;
        r.target = target;
        return r;
    endfunction

    // Model state: mode 0=BOOT 1=RUN 2=HALT, at most one buffered redirect.
    int          m_mode = 0;
    redir_t      m_pend[$];
    logic [31:0] m_pc_next = 32'h0;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          lit_en = 1'b0;
    string       lit_name;
    logic        lit_pcw, lit_fif, lit_fex;
    logic [31:0] lit_npc;
    logic [1:0]  lit_st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        redir_t      req[$];
        redir_t      sel;
        logic        e_pcw, e_fif, e_fex;
        logic [31:0] e_npc;
        logic [1:0]  e_st;

        req.delete();
        sel   = mk(0, 32'h0);
        e_pcw = 1'b0;
        e_fif = 1'b0;
        e_fex = 1'b0;
        e_npc = pc + 32'd4;
        e_st  = 2'(m_mode);

        if (!rst) begin
            e_npc = RV;
            e_st  = 2'd0;
        end else if (m_mode == 0) begin
            e_pcw = 1'b1;
            e_npc = RV;
        end else begin
            if (trap) req.push_back(mk(TRAP, TV));
            if (m_mode == 1) begin
                if (br_taken)           req.push_back(mk(BRANCH, br_target));
                if (m_pend.size() > 0)  req.push_back(m_pend[0]);
                if (jmp_valid && !stall) req.push_back(mk(JUMP, jmp_target));
            end
            if (req.size() > 0) begin
                sel = req[0];
                if (imem_ready) begin
                    e_pcw = 1'b1;
                    e_npc = sel.target;
                    e_fif = 1'b1;
                    e_fex = (sel.kind != JUMP);
                end
            end else if (m_mode == 1) begin
                e_pcw = imem_ready && !stall && !halt_req;
            end
        end

        check("PCWrite", 32'(PCWrite), 32'(e_pcw));
        if (e_pcw || !rst) check("n_pc", n_pc, e_npc);
        check("flush_if_id", 32'(flush_if_id), 32'(e_fif));
        check("flush_id_ex", 32'(flush_id_ex), 32'(e_fex));
        check("state", 32'(state), 32'(e_st));

        if (lit_en) begin
            check({lit_name, ".PCWrite"}, 32'(PCWrite), 32'(lit_pcw));
            if (lit_pcw || !rst) check({lit_name, ".n_pc"}, n_pc, lit_npc);
            check({lit_name, ".flush_if_id"}, 32'(flush_if_id), 32'(lit_fif));
            check({lit_name, ".flush_id_ex"}, 32'(flush_id_ex), 32'(lit_fex));
            check({lit_name, ".state"}, 32'(state), 32'(lit_st));
        end

        m_pc_next = e_pcw ? e_npc : pc;
        if (!rst) begin
            m_mode = 0;
            m_pend.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (req.size() > 0) begin
            m_mode = 1;
            if (imem_ready) begin
                m_pend.delete();
            end else if (!(sel.kind == BRANCH && m_pend.size() > 0 && m_pend[0].kind == TRAP)) begin
                m_pend.delete();
                m_pend.push_back(sel);
            end
        end else if (m_mode == 1 && halt_req) begin
            m_mode = 2;
        end else if (m_mode == 2 && resume) begin
            m_mode = 1;
        end
    end

    // Advance one cycle; the bench plays the PC register using the model's next PC.
    task automatic next();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
        pc     = m_pc_next;
    endtask

    task automatic expect_out(input string nm, input logic pcw, input logic [31:0] npc,
                              input logic fif, input logic fex, input logic [1:0] st);
        lit_en   = 1'b1;
        lit_name = nm;
        lit_pcw  = pcw;
        lit_npc  = npc;
        lit_fif  = fif;
        lit_fex  = fex;
        lit_st   = st;
    endtask

    initial begin
        rst = 1'b0; pc = 32'h0; imem_ready = 1'b1; stall = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; jmp_valid = 1'b0; jmp_target = 32'h0;
        trap = 1'b0; halt_req = 1'b0; resume = 1'b0;

        @(posedge clk); #1;
        expect_out("in_reset", 1'b0, RV, 1'b0, 1'b0, 2'd0);
        next();
        rst = 1'b1;
        expect_out("boot", 1'b1, 32'h0, 1'b0, 1'b0, 2'd0);
        next(); expect_out("seq4", 1'b1, 32'h4, 1'b0, 1'b0, 2'd1);
        next(); expect_out("seq8", 1'b1, 32'h8, 1'b0, 1'b0, 2'd1);

        next(); pc = 32'h10; stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h200;
        expect_out("stall0", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); expect_out("stall1", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); stall = 1'b0;
        expect_out("jump_after_stall", 1'b1, 32'h200, 1'b1, 1'b0, 2'd1);

        next(); jmp_target = 32'h80; br_taken = 1'b1; br_target = 32'h40;
        expect_out("br_over_jmp", 1'b1, 32'h40, 1'b1, 1'b1, 2'd1);

        next(); br_taken = 1'b0; imem_ready = 1'b0;
        expect_out("pend_jmp", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); jmp_valid = 1'b0; br_taken = 1'b1;
        expect_out("pend_br", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); br_taken = 1'b0;
        expect_out("pend_wait", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); imem_ready = 1'b1;
        expect_out("pend_apply", 1'b1, 32'h40, 1'b1, 1'b1, 2'd1);

        next(); pc = 32'h20; halt_req = 1'b1;
        expect_out("halt_enter", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_out("halted", 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
            next();
        end
        trap = 1'b1;
        expect_out("halt_trap", 1'b1, TV, 1'b1, 1'b1, 2'd2);
        next(); trap = 1'b0;
        expect_out("after_trap", 1'b1, 32'h104, 1'b0, 1'b0, 2'd1);

        next(); halt_req = 1'b1;
        expect_out("halt2_enter", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); halt_req = 1'b0;
        expect_out("halt2", 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
        next(); resume = 1'b1;
        expect_out("resume", 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
        next(); resume = 1'b0;
        expect_out("after_resume", 1'b1, 32'h108, 1'b0, 1'b0, 2'd1);

        next(); pc = 32'hFFFF_FFFC;
        expect_out("wrap", 1'b1, 32'h0, 1'b0, 1'b0, 2'd1);

        next(); halt_req = 1'b1;
        next(); halt_req = 1'b0; imem_ready = 1'b0; trap = 1'b1;
        expect_out("halt_trap_notready", 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
        next(); trap = 1'b0; imem_ready = 1'b1;
        expect_out("pend_trap_apply", 1'b1, TV, 1'b1, 1'b1, 2'd1);

        next(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        expect_out("pend_before_rst", 1'b0, 32'h0, 1'b0, 1'b0, 2'd1);
        next(); br_taken = 1'b0; rst = 1'b0;
        expect_out("rst_mid", 1'b0, RV, 1'b0, 1'b0, 2'd0);
        next(); rst = 1'b1; imem_ready = 1'b1;
        expect_out("reboot", 1'b1, RV, 1'b0, 1'b0, 2'd0);
        next(); expect_out("reboot_seq", 1'b1, 32'h4, 1'b0, 1'b0, 2'd1);
        next(); stall = 1'b1; trap = 1'b1;
        expect_out("trap_over_stall", 1'b1, TV, 1'b1, 1'b1, 2'd1);
        next(); stall = 1'b0; trap = 1'b0;
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC sequencer and write-enable controller for the fetch stage's program counter register. Each cycle it chooses the next PC from trap, EX-stage branch, ID-stage jump or sequential increment, and drives the PC register's `PCWrite`/`n_pc` inputs. It holds the PC on hazard stalls, fetch back-pressure or halt, and buffers one redirect that arrives while fetch is not ready. It also generates the pipeline flush strobes that go with each redirect.

## Interface
- `W`, 32, PC width
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `TRAP_VECTOR`, 32'h0000_0100, trap handler address

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pc`  in  W  current PC register value
- `imem_ready`  in  1  fetch can accept a new PC this cycle
- `stall`  in  1  ID hazard stall (load-use)
- `br_taken`  in  1  EX branch resolved taken
- `br_target`  in  W  EX branch target
- `jmp_valid`  in  1  ID unconditional jump
- `jmp_target`  in  W  ID jump target
- `trap`  in  1  exception request
- `halt_req`  in  1  request to stop fetching
- `resume`  in  1  leave HALT
- `PCWrite`  out  1  PC register enable
- `n_pc`  out  W  next PC
- `flush_if_id`  out  1  squash IF/ID contents
- `flush_id_ex`  out  1  squash ID/EX contents
- `state`  out  2  BOOT=0, RUN=1, HALT=2

## Operation
- Outputs are combinational from state, the pending register and the inputs. State and pending are the only flops.
- Redirect priority: trap > br_taken > pending > jmp_valid > sequential `pc + 4`. `pc + 4` wraps modulo 2^W. Targets pass through unmodified.
- `jmp_valid` is ignored while `stall`=1, because the ID instruction will reassert it. `br_taken` and `trap` override `stall`.
- BOOT: `PCWrite`=1 and `n_pc`=RESET_VECTOR for one cycle, independent of `imem_ready`, then go to RUN.
- RUN, no redirect: `PCWrite` = `imem_ready & ~stall`, `n_pc`=`pc+4`.
- RUN with a redirect and `imem_ready`=1:
  - `PCWrite`=1 and `n_pc`=target.
  - `flush_if_id`=1.
  - `flush_id_ex`=1 only for trap or branch, including a pending trap or branch.
  - Clear pending.
- RUN with a redirect and `imem_ready`=0:
  - `PCWrite`=0 and no flush.
  - Latch target and type into pending.
  - A later trap overwrites any pending entry. A later branch overwrites a pending jump. Nothing overwrites a pending trap.
- `halt_req` in RUN with no redirect and no pending: go to HALT at the edge. `PCWrite`=0 in that cycle.
- HALT:
  - `PCWrite`=0.
  - `resume`=1 returns to RUN next cycle.
  - `trap` in HALT is applied as a RUN redirect (subject to `imem_ready`) and also moves to RUN.
  - `br_taken` and `jmp_valid` are ignored in HALT.
- Simultaneous `halt_req` and a redirect: the redirect wins and halt_req is dropped. The requester must hold it.

## Timing
- During reset (`rst`=0): state=BOOT, pending cleared, `PCWrite`=0, `n_pc`=RESET_VECTOR, flushes=0. Asserting reset mid-operation discards the pending redirect immediately.
- BOOT `PCWrite` occurs in the first cycle after `rst` deasserts.
- Redirect latency: a redirect presented in cycle t with `imem_ready`=1 loads the PC at the end of t. With `imem_ready` low, it loads at the end of the first cycle in which `imem_ready`=1.
- Flush strobes are single-cycle and coincide with the `PCWrite` that applies the redirect.
- At most one pending entry exists.

## Test plan
- Reset release with `imem_ready`=1, no events → `PCWrite`=1 with `n_pc`=0x0, then `n_pc`=0x4, 0x8; `state` goes 0→1.
- `stall`=1 for 2 cycles at pc=0x10 with `jmp_valid`=1 → `PCWrite`=0 for both cycles. Stall released with `jmp_valid` still 1 → `n_pc`=`jmp_target`, `flush_if_id`=1, `flush_id_ex`=0.
- `br_taken`=1 (target 0x40) and `jmp_valid`=1 (0x80) in the same cycle → `n_pc`=0x40 and both flushes=1.
- `imem_ready`=0, jump to 0x80 at t, branch to 0x40 at t+1, ready at t+3 → no write until t+3, then `n_pc`=0x40 with `flush_id_ex`=1.
- `halt_req` at pc=0x20 → HALT, `PCWrite` stays 0 for 5 cycles. Then `trap` → `n_pc`=0x100, `state`=RUN. Repeat halt, then `resume` → `n_pc`=`pc+4` next cycle.
- `pc`=0xFFFFFFFC sequential → `n_pc`=0x0. Assert `rst` while a pending redirect exists → `PCWrite`=0 immediately; after release `n_pc`=RESET_VECTOR, not the pending target.
